ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction fetch stage for the basic RV32I core.
- Produces the 32-bit instruction word and its PC that the ID-stage control decoder consumes: the sending end of the decoder's inst interface.
- Owns the PC register and a single-outstanding request/acknowledge handshake to instruction memory.
- Accepts a stall from ID and a redirect (jump/branch target) from later stages, with a one-entry skid buffer so no fetched word is lost.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
NOP_INST, 32'h0000_0013, word driven on inst when no valid instruction is present (addi x0,x0,0).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  instruction memory request
imem_addr  out  32  request address, word aligned
imem_ack  in  1  response valid this cycle; may assert in the same cycle as imem_req or later
imem_rdata  in  32  instruction word, sampled only when imem_ack=1
stall  in  1  ID cannot accept a new instruction this cycle
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new fetch target; bits [1:0] ignored (treated as 0)
inst  out  32  instruction to decoder (registered)
pc_out  out  32  PC of inst (registered)
inst_valid  out  1  inst/pc_out hold a real instruction

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Reset has priority over all inputs.
- Reset values:
  - pc=RESET_PC, req_addr=RESET_PC, imem_req=0.
  - inst=NOP_INST, pc_out=0, inst_valid=0.
  - Skid buffer empty, state=FETCH, but imem_req stays 0 during the reset cycle.
- Reset asserted mid-request: the outstanding request is abandoned. The first cycle after reset deasserts drives imem_req=1 with imem_addr=RESET_PC.
- Handshake rules:
  - imem_addr is driven from the req_addr register and is stable while imem_req=1 until imem_ack.
  - At most one request is outstanding.
  - imem_ack while imem_req=0 is ignored.
- FETCH (imem_req=1, imem_addr=req_addr):
  - ack & redirect: drop rdata; pc, req_addr <= redirect_pc; inst_valid<=0; stay FETCH.
  - ack & !stall: inst<=rdata; pc_out<=pc; inst_valid<=1; pc, req_addr <= pc+4.
  - ack & stall: buf<=rdata; buf_pc<=pc; pc<=pc+4; go to HOLD. Outputs are unchanged.
  - !ack & redirect: pc<=redirect_pc; inst_valid<=0; go to SQUASH. req_addr keeps the old address.
  - !ack & !stall: inst_valid<=0 and inst<=NOP_INST (bubble).
  - !ack & stall: outputs hold.
- SQUASH (imem_req=1, old req_addr):
  - On ack, discard rdata, set req_addr<=pc, go to FETCH.
  - A further redirect here updates pc only.
- HOLD (imem_req=0):
  - redirect: discard buf; pc, req_addr <= redirect_pc; inst_valid<=0; go to FETCH.
  - Else !stall: inst<=buf, pc_out<=buf_pc, inst_valid<=1; req_addr<=pc; go to FETCH.
  - Else hold.
- Redirect always beats stall and clears inst_valid on the next edge.
- Fetch latency: minimum 1 cycle from imem_ack to inst_valid. Sustained throughput is 1 inst/cycle with a same-cycle-ack memory.
- PC arithmetic: modulo 2^32, so 32'hFFFF_FFFC + 4 wraps to 0.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- When defined: adds outputs perf_fetched[31:0] and perf_bubbles[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - perf_fetched increments on each non-discarded imem_ack.
  - perf_bubbles increments on each cycle where stall=0 and inst_valid=0 after the edge.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, same-cycle-ack memory returning addr-derived words, stall=0 -> imem_addr 0,4,8,...; inst_valid=1 from cycle 2; pc_out 0,4,8 back-to-back.
- stall high 3 cycles while ack arrives for addr 8 -> inst holds word@4, imem_req drops. On release, word@8 appears next cycle, then fetch resumes at 12.
- Memory with 2-cycle latency; redirect to 0x100 one cycle after req for 0x10 -> req for 0x10 held until ack and its data never appears; next req addr 0x100; pc_out=0x100.
- redirect to 0x203 coincident with ack -> rdata dropped, inst_valid=0 next cycle, next imem_addr=0x200.
- RESET_PC=32'hFFFF_FFFC -> second request address 0x0000_0000.
- Reset asserted mid-HOLD -> next cycle inst_valid=0, inst=0x00000013, then request at RESET_PC; with IFETCH_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/ifetch_unit.sv
// RV32I instruction fetch stage: owns the PC, runs a single-outstanding imem handshake
// and feeds a registered inst/pc_out pair to ID. Optional counters: IFETCH_PERF_CNT_EN.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] inst,
   output logic [31:0] pc_out,
   output logic        inst_valid
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_bubbles
`endif
);

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_SQUASH,
      ST_HOLD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] skid_q, skid_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] target_pc;
   logic [31:0] pc_inc;

   assign target_pc = redirect_pc & ~32'd3;
   assign pc_inc    = pc_q + 32'd4;

   // No request while the skid buffer is full, nor during the reset cycle itself.
   assign imem_req   = (state_q != ST_HOLD) && !reset;
   assign imem_addr  = req_addr_q;
   assign inst       = inst_q;
   assign pc_out     = pc_out_q;
   assign inst_valid = inst_valid_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      inst_d       = inst_q;
      pc_out_d     = pc_out_q;
      inst_valid_d = inst_valid_q;
      skid_d       = skid_q;
      skid_pc_d    = skid_pc_q;

      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               if (redirect) begin
                  pc_d         = target_pc;
                  req_addr_d   = target_pc;
                  inst_valid_d = 1'b0;
                  inst_d       = NOP_INST;
               end else if (!stall) begin
                  inst_d       = imem_rdata;
                  pc_out_d     = pc_q;
                  inst_valid_d = 1'b1;
                  pc_d         = pc_inc;
                  req_addr_d   = pc_inc;
               end else begin
                  skid_d    = imem_rdata;
                  skid_pc_d = pc_q;
                  pc_d      = pc_inc;
                  state_d   = ST_HOLD;
               end
            end else if (redirect) begin
               // Request stays on the bus at its old address until acked, then is dropped.
               pc_d         = target_pc;
               inst_valid_d = 1'b0;
               inst_d       = NOP_INST;
               state_d      = ST_SQUASH;
            end else if (!stall) begin
               inst_valid_d = 1'b0;
               inst_d       = NOP_INST;
            end
         end

         ST_SQUASH: begin
            if (redirect) begin
               pc_d = target_pc;
            end
            if (imem_ack) begin
               req_addr_d = redirect ? target_pc : pc_q;
               state_d    = ST_FETCH;
            end
         end

         ST_HOLD: begin
            if (redirect) begin
               pc_d         = target_pc;
               req_addr_d   = target_pc;
               inst_valid_d = 1'b0;
               inst_d       = NOP_INST;
               state_d      = ST_FETCH;
            end else if (!stall) begin
               inst_d       = skid_q;
               pc_out_d     = skid_pc_q;
               inst_valid_d = 1'b1;
               req_addr_d   = pc_q;
               state_d      = ST_FETCH;
            end
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         req_addr_q   <= RESET_PC;
         inst_q       <= NOP_INST;
         pc_out_q     <= '0;
         inst_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_addr_q   <= req_addr_d;
         inst_q       <= inst_d;
         pc_out_q     <= pc_out_d;
         inst_valid_q <= inst_valid_d;
         skid_q       <= skid_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_bubbles_q, perf_bubbles_d;
   logic        fetch_take;

   // A response counts as fetched unless a redirect or squash throws it away.
   assign fetch_take = (state_q == ST_FETCH) && imem_ack && !redirect;

   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_bubbles_d = perf_bubbles_q;
      if (fetch_take && (perf_fetched_q != '1)) begin
         perf_fetched_d = perf_fetched_q + 32'd1;
      end
      if (!stall && !inst_valid_d && (perf_bubbles_q != '1)) begin
         perf_bubbles_d = perf_bubbles_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_bubbles_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_bubbles_q <= perf_bubbles_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a randomized run checked
// against an instruction-stream model (program order, redirect targets, stall holds).
module tb_ifetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, stall, redirect;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_ack, inst_valid;
   logic [31:0] imem_addr, imem_rdata, inst, pc_out;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_rdata, w_inst, w_pc_out;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_bubbles, w_perf_fetched, w_perf_bubbles;
`endif

   int n_vec = 0;
   int n_bad = 0;
   int mem_lat = 0;
   bit spurious = 1'b0;
   int lat_left = -1;
   bit prev_wait = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] ack_log[$];

   function automatic logic [31:0] word_of(input logic [31:0] a);
      word_of = {a[15:0], a[31:16]} ^ 32'hC0DE_5A01;
   endfunction

   ifetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .inst(inst), .pc_out(pc_out), .inst_valid(inst_valid)
`ifdef IFETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
   );

   // Second instance with a wrapping reset PC and an always-ready memory.
   assign w_rdata = word_of(w_addr);
   ifetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0013)) u_wrap (
      .clk(clk), .reset(reset), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_req), .imem_rdata(w_rdata), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .inst(w_inst), .pc_out(w_pc_out), .inst_valid(w_valid)
`ifdef IFETCH_PERF_CNT_EN
      , .perf_fetched(w_perf_fetched), .perf_bubbles(w_perf_bubbles)
`endif
   );

   // Memory responder: fixed or random latency, optional acks while no request is up.
   initial begin
      imem_ack = 1'b0;
      imem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (imem_req === 1'b1) begin
            if (prev_wait) begin
               n_vec++;
               if (imem_addr !== prev_addr) begin
                  n_bad++;
                  $display("FAIL addr_stable: imem_addr=%h, held request was %h", imem_addr, prev_addr);
               end
            end
            if (lat_left < 0) lat_left = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
            if (lat_left == 0) begin
               imem_ack = 1'b1;
               imem_rdata = word_of(imem_addr);
               ack_log.push_back(imem_addr);
               lat_left = -1;
               prev_wait = 1'b0;
            end else begin
               imem_ack = 1'b0;
               imem_rdata = $urandom;
               lat_left--;
               prev_wait = 1'b1;
               prev_addr = imem_addr;
            end
         end else begin
            lat_left = -1;
            prev_wait = 1'b0;
            imem_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = $urandom;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      step();
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      mem_lat = 0;
      spurious = 1'b0;
      reset = 1'b1;
      step();
      step();
      n_vec++;
      if (inst !== NOP || pc_out !== 32'h0 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: inst=%h pc_out=%h valid=%b req=%b, required 00000013/0/0/0",
                  inst, pc_out, inst_valid, imem_req);
      end
`ifdef IFETCH_PERF_CNT_EN
      n_vec++;
      if (perf_fetched !== 32'h0 || perf_bubbles !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_perf: fetched=%0d bubbles=%0d, required 0/0", perf_fetched, perf_bubbles);
      end
`endif
      reset = 1'b0;
      #1;
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_release: req=%b addr=%h, required 1/00000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_stream();
      mem_lat = 0;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         n_vec++;
         if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1))) begin
            n_bad++;
            $display("FAIL stream_addr c%0d: req=%b addr=%h, required 1/%h", k, imem_req, imem_addr, 4 * (k - 1));
         end
         n_vec++;
         if (k == 1) begin
            if (inst_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL stream_first c1: valid=%b, required 0", inst_valid);
            end
         end else if (inst_valid !== 1'b1 || pc_out !== 32'(4 * (k - 2)) || inst !== word_of(32'(4 * (k - 2)))) begin
            n_bad++;
            $display("FAIL stream_out c%0d: valid=%b pc_out=%h inst=%h, required 1/%h/%h",
                     k, inst_valid, pc_out, inst, 4 * (k - 2), word_of(32'(4 * (k - 2))));
         end
`ifdef IFETCH_PERF_CNT_EN
         n_vec++;
         if (perf_fetched !== 32'(k - 1) || perf_bubbles !== 32'h0) begin
            n_bad++;
            $display("FAIL stream_perf c%0d: fetched=%0d bubbles=%0d, required %0d/0",
                     k, perf_fetched, perf_bubbles, k - 1);
         end
`endif
         step();
      end
   endtask

   task automatic test_stall();
      mem_lat = 0;
      do_reset();
      step();
      step();
      stall = 1'b1;
      for (int k = 4; k <= 6; k++) begin
         step();
         n_vec++;
         if (inst_valid !== 1'b1 || pc_out !== 32'h4 || inst !== word_of(32'h4) || imem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold c%0d: valid=%b pc_out=%h inst=%h req=%b, required 1/4/%h/0",
                     k, inst_valid, pc_out, inst, imem_req, word_of(32'h4));
         end
      end
      stall = 1'b0;
      step();
      n_vec++;
      if (inst_valid !== 1'b1 || pc_out !== 32'h8 || inst !== word_of(32'h8) ||
          imem_req !== 1'b1 || imem_addr !== 32'hC) begin
         n_bad++;
         $display("FAIL stall_release: valid=%b pc_out=%h inst=%h req=%b addr=%h, required 1/8/%h/1/c",
                  inst_valid, pc_out, inst, imem_req, imem_addr, word_of(32'h8));
      end
      step();
      n_vec++;
      if (inst_valid !== 1'b1 || pc_out !== 32'hC) begin
         n_bad++;
         $display("FAIL stall_resume: valid=%b pc_out=%h, required 1/c", inst_valid, pc_out);
      end
   endtask

   task automatic test_squash();
      int i;
      mem_lat = 2;
      do_reset();
      for (i = 0; i < 40; i++) begin
         if (imem_req === 1'b1 && imem_addr === 32'h10) break;
         step();
      end
      n_vec++;
      if (i >= 40) begin
         n_bad++;
         $display("FAIL squash_wait: no request for 00000010 within 40 cycles, required one");
      end
      ack_log.delete();
      step();
      redirect = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      n_vec++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
         n_bad++;
         $display("FAIL squash_held: valid=%b req=%b addr=%h, required 0/1/10", inst_valid, imem_req, imem_addr);
      end
      step();
      n_vec++;
      if (imem_addr !== 32'h100) begin
         n_bad++;
         $display("FAIL squash_next_addr: addr=%h, required 100", imem_addr);
      end
      for (i = 0; i < 20; i++) begin
         if (inst_valid === 1'b1) break;
         step();
      end
      n_vec++;
      if (inst_valid !== 1'b1 || pc_out !== 32'h100 || inst !== word_of(32'h100)) begin
         n_bad++;
         $display("FAIL squash_first: valid=%b pc_out=%h inst=%h, required 1/100/%h",
                  inst_valid, pc_out, inst, word_of(32'h100));
      end
      n_vec++;
      if (ack_log.size() < 2 || ack_log[0] !== 32'h10 || ack_log[1] !== 32'h100) begin
         n_bad++;
         $display("FAIL squash_acks: acked sequence size=%0d, required 10 then 100", ack_log.size());
      end
   endtask

   task automatic test_redirect_ack();
      mem_lat = 0;
      do_reset();
      step();
      redirect = 1'b1;
      redirect_pc = 32'h203;
      step();
      redirect = 1'b0;
      n_vec++;
      if (inst_valid !== 1'b0 || inst !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
         n_bad++;
         $display("FAIL redir_ack: valid=%b inst=%h req=%b addr=%h, required 0/00000013/1/200",
                  inst_valid, inst, imem_req, imem_addr);
      end
      step();
      n_vec++;
      if (inst_valid !== 1'b1 || pc_out !== 32'h200 || inst !== word_of(32'h200)) begin
         n_bad++;
         $display("FAIL redir_target: valid=%b pc_out=%h inst=%h, required 1/200/%h",
                  inst_valid, pc_out, inst, word_of(32'h200));
      end
   endtask

   task automatic test_wrap();
      do_reset();
      n_vec++;
      if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
         n_bad++;
         $display("FAIL wrap_first: req=%b addr=%h, required 1/fffffffc", w_req, w_addr);
      end
      step();
      n_vec++;
      if (w_addr !== 32'h0 || w_valid !== 1'b1 || w_pc_out !== 32'hFFFF_FFFC) begin
         n_bad++;
         $display("FAIL wrap_second: addr=%h valid=%b pc_out=%h, required 0/1/fffffffc", w_addr, w_valid, w_pc_out);
      end
      step();
      n_vec++;
      if (w_pc_out !== 32'h0 || w_inst !== word_of(32'h0) || w_addr !== 32'h4) begin
         n_bad++;
         $display("FAIL wrap_third: pc_out=%h inst=%h addr=%h, required 0/%h/4", w_pc_out, w_inst, w_addr, word_of(32'h0));
      end
   endtask

   task automatic test_reset_hold();
      mem_lat = 0;
      do_reset();
      step();
      stall = 1'b1;
      step();
      n_vec++;
      if (imem_req !== 1'b0) begin
         n_bad++;
         $display("FAIL rsthold_in_hold: req=%b, required 0", imem_req);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      stall = 1'b0;
      #1;
      n_vec++;
      if (inst_valid !== 1'b0 || inst !== NOP || pc_out !== 32'h0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_bad++;
         $display("FAIL rsthold_after: valid=%b inst=%h pc_out=%h req=%b addr=%h, required 0/00000013/0/1/0",
                  inst_valid, inst, pc_out, imem_req, imem_addr);
      end
`ifdef IFETCH_PERF_CNT_EN
      n_vec++;
      if (perf_fetched !== 32'h0 || perf_bubbles !== 32'h0) begin
         n_bad++;
         $display("FAIL rsthold_perf: fetched=%0d bubbles=%0d, required 0/0", perf_fetched, perf_bubbles);
      end
`endif
      step();
      n_vec++;
      if (inst_valid !== 1'b1 || pc_out !== 32'h0 || inst !== word_of(32'h0)) begin
         n_bad++;
         $display("FAIL rsthold_refetch: valid=%b pc_out=%h inst=%h, required 1/0/%h",
                  inst_valid, pc_out, inst, word_of(32'h0));
      end
   endtask

   // Model: ID must see the program-order stream from each restart point; a stalled
   // instruction stays put, a redirect empties the slot on the next edge.
   task automatic test_random();
      logic [31:0] exp_pc, hold_pc, hold_inst;
      bit exp_inv, hold_exp;
      int idle, max_idle, consumed;
      exp_inv = 1'b0;
      hold_exp = 1'b0;
      hold_pc = '0;
      hold_inst = '0;
      idle = 0;
      max_idle = 0;
      consumed = 0;
      mem_lat = -1;
      spurious = 1'b1;
      do_reset();
      exp_pc = 32'h0;
      for (int c = 0; c < 600; c++) begin
         if (exp_inv) begin
            n_vec++;
            if (inst_valid !== 1'b0) begin
               n_bad++;
               $display("FAIL rand_redirect_clear c%0d: valid=%b, required 0", c, inst_valid);
            end
         end
         if (hold_exp) begin
            n_vec++;
            if (inst_valid !== 1'b1 || pc_out !== hold_pc || inst !== hold_inst) begin
               n_bad++;
               $display("FAIL rand_stall_hold c%0d: valid=%b pc_out=%h inst=%h, required 1/%h/%h",
                        c, inst_valid, pc_out, inst, hold_pc, hold_inst);
            end
         end
         n_vec++;
         if (inst_valid === 1'b1) begin
            if (pc_out !== exp_pc || inst !== word_of(exp_pc)) begin
               n_bad++;
               $display("FAIL rand_stream c%0d: pc_out=%h inst=%h, required %h/%h",
                        c, pc_out, inst, exp_pc, word_of(exp_pc));
            end
         end else if (inst_valid !== 1'b0 || inst !== NOP) begin
            n_bad++;
            $display("FAIL rand_bubble c%0d: valid=%b inst=%h, required 0/00000013", c, inst_valid, inst);
         end
         stall = ($urandom_range(0, 9) < 3);
         redirect = ($urandom_range(0, 19) == 0);
         redirect_pc = 32'($urandom_range(0, 1023));
         exp_inv = redirect;
         hold_exp = !redirect && stall && (inst_valid === 1'b1);
         hold_pc = pc_out;
         hold_inst = inst;
         if (redirect) begin
            exp_pc = redirect_pc & ~32'd3;
            idle = 0;
         end else if (!stall) begin
            if (inst_valid === 1'b1) begin
               exp_pc = exp_pc + 32'd4;
               consumed++;
               idle = 0;
            end else begin
               idle++;
            end
         end
         if (idle > max_idle) max_idle = idle;
         step();
      end
      stall = 1'b0;
      redirect = 1'b0;
      spurious = 1'b0;
      mem_lat = 0;
      n_vec++;
      if (max_idle > 20 || consumed < 60) begin
         n_bad++;
         $display("FAIL rand_progress: max idle=%0d consumed=%0d, required <=20 and >=60", max_idle, consumed);
      end
   endtask

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      test_reset();
      test_stream();
      test_stall();
      test_squash();
      test_redirect_ack();
      test_wrap();
      test_reset_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
